// File: rtl/vga_crtc_regs_if.sv
// CPU data-bus bundle for the VGA CRTC register file.
// Word-addressed, byte-lane enabled, single-cycle strobe with registered ack.
interface vga_crtc_regs_if;
  logic        cs;
  logic [19:1] data_m_addr;
  logic [15:0] data_m_data_in;
  logic [15:0] data_m_data_out;
  logic [1:0]  data_m_bytesel;
  logic        data_m_wr_en;
  logic        data_m_access;
  logic        data_m_ack;

  modport master (
    output cs,
    output data_m_addr,
    output data_m_data_in,
    output data_m_bytesel,
    output data_m_wr_en,
    output data_m_access,
    input  data_m_data_out,
    input  data_m_ack
  );

  modport slave (
    input  cs,
    input  data_m_addr,
    input  data_m_data_in,
    input  data_m_bytesel,
    input  data_m_wr_en,
    input  data_m_access,
    output data_m_data_out,
    output data_m_ack
  );
endinterface

// File: rtl/vga_crtc_regs.sv
// CRTC register file: index/value access, status, vsync-shadowed
// start/cursor registers and a frame-based cursor blink generator.
module vga_crtc_regs #(
  parameter int POS_W        = 15,
  parameter int SCAN_W       = 3,
  parameter int BLINK_FRAMES = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  vga_crtc_regs_if.slave    bus,
  input  logic              vga_vsync,
  input  logic              vga_hsync,
  output logic              cursor_enabled,
  output logic              cursor_visible,
  output logic [POS_W-1:0]  cursor_pos,
  output logic [POS_W-1:0]  start_addr,
  output logic [SCAN_W-1:0] cursor_scan_start,
  output logic [SCAN_W-1:0] cursor_scan_end
);

  localparam int CNT_W = $clog2(BLINK_FRAMES / 2);
  localparam logic [CNT_W-1:0] SLOW_M1 =
    CNT_W'(BLINK_FRAMES / 2 - 1);
  localparam logic [CNT_W-1:0] FAST_M1 =
    CNT_W'(BLINK_FRAMES / 4 - 1);

  logic [4:0]        idx_q, idx_d;
  logic [1:0]        mode_q, mode_d;
  logic [SCAN_W-1:0] ss_q, ss_d;
  logic [SCAN_W-1:0] se_q, se_d;
  logic [POS_W-1:0]  pst_q, pst_d;
  logic [POS_W-1:0]  pcur_q, pcur_d;
  logic [POS_W-1:0]  st_q, st_d;
  logic [POS_W-1:0]  cur_q, cur_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              phase_q, phase_d;
  logic              flag_q, flag_d;
  logic              vs_q, vs_d;
  logic              armed_q, armed_d;
  logic              ack_q, ack_d;
  logic [15:0]       rdat_q, rdat_d;

  logic        sel, wr, rd;
  logic [2:0]  a;
  logic        idx_wr, val_wr, mode_wr, stat_rd;
  logic [4:0]  new_idx;
  logic [7:0]  wdat;
  logic        vs_rise;
  logic [15:0] st16, cu16;
  logic [7:0]  md8, se8, vbyte, stat8;
  logic [7:0]  lo, hi;
  logic [CNT_W-1:0] lim;
  logic        unused_bits;

  assign unused_bits = ^{bus.data_m_addr[19:4],
                         bus.data_m_data_in[7:5]};

  assign sel  = bus.cs & bus.data_m_access;
  assign wr   = sel & bus.data_m_wr_en;
  assign rd   = sel & ~bus.data_m_wr_en;
  assign a    = bus.data_m_addr[3:1];
  assign wdat = bus.data_m_data_in[15:8];

  assign idx_wr  = wr & (a == 3'b010) & bus.data_m_bytesel[0];
  assign val_wr  = wr & (a == 3'b010) & bus.data_m_bytesel[1];
  assign stat_rd = rd & (a == 3'b101) & bus.data_m_bytesel[0];
  assign new_idx = idx_wr ? bus.data_m_data_in[4:0] : idx_q;

  // Arming keeps a vsync already high at reset release from counting.
  assign vs_rise = vga_vsync & ~vs_q & armed_q;

  assign st16  = 16'(pst_q);
  assign cu16  = 16'(pcur_q);
  assign se8   = 8'(se_q);
  assign stat8 = {flag_q, 3'b000, vga_vsync,
                  2'b00, vga_hsync | vga_vsync};

  always_comb begin
    md8      = 8'(ss_q);
    md8[5:4] = mode_q;
  end

  always_comb begin
    vbyte = 8'h00;
    unique case (1'b1)
      (idx_q == 5'h0A): vbyte = md8;
      (idx_q == 5'h0B): vbyte = se8;
      (idx_q == 5'h0C): vbyte = st16[15:8];
      (idx_q == 5'h0D): vbyte = st16[7:0];
      (idx_q == 5'h0E): vbyte = cu16[15:8];
      (idx_q == 5'h0F): vbyte = cu16[7:0];
      default:          vbyte = 8'h00;
    endcase
  end

  always_comb begin
    idx_d   = idx_q;
    mode_d  = mode_q;
    ss_d    = ss_q;
    se_d    = se_q;
    pst_d   = pst_q;
    pcur_d  = pcur_q;
    mode_wr = 1'b0;

    if (idx_wr) idx_d = bus.data_m_data_in[4:0];

    if (val_wr) begin
      unique case (1'b1)
        (new_idx == 5'h0A): begin
          mode_d  = wdat[5:4];
          ss_d    = wdat[SCAN_W-1:0];
          mode_wr = 1'b1;
        end
        (new_idx == 5'h0B): se_d = wdat[SCAN_W-1:0];
        (new_idx == 5'h0C):
          pst_d = POS_W'({wdat, st16[7:0]});
        (new_idx == 5'h0D):
          pst_d = POS_W'({st16[15:8], wdat});
        (new_idx == 5'h0E):
          pcur_d = POS_W'({wdat, cu16[7:0]});
        (new_idx == 5'h0F):
          pcur_d = POS_W'({cu16[15:8], wdat});
        default: ;
      endcase
    end
  end

  // Live registers see the pending value from before any same-cycle write.
  always_comb begin
    st_d  = st_q;
    cur_d = cur_q;
    if (vs_rise) begin
      st_d  = pst_q;
      cur_d = pcur_q;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    lim     = (mode_q == 2'b11) ? FAST_M1 : SLOW_M1;
    if (mode_wr) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (vs_rise) begin
      if (cnt_q >= lim) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    flag_d  = flag_q;
    if (stat_rd) flag_d = 1'b0;
    if (vs_rise) flag_d = 1'b1;
    vs_d    = vga_vsync;
    armed_d = armed_q | ~vga_vsync;
  end

  always_comb begin
    lo     = 8'h00;
    hi     = 8'h00;
    rdat_d = 16'h0000;
    ack_d  = sel;
    unique case (1'b1)
      (a == 3'b010): begin
        lo = {3'b000, idx_q};
        hi = vbyte;
      end
      (a == 3'b101): lo = stat8;
      default: ;
    endcase
    if (rd) begin
      rdat_d[15:8] = bus.data_m_bytesel[1] ? hi : 8'h00;
      rdat_d[7:0]  = bus.data_m_bytesel[0] ? lo : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q   <= '0;
      mode_q  <= 2'b00;
      ss_q    <= '0;
      se_q    <= '0;
      pst_q   <= '0;
      pcur_q  <= '0;
      st_q    <= '0;
      cur_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b1;
      flag_q  <= 1'b0;
      vs_q    <= 1'b0;
      armed_q <= 1'b0;
      ack_q   <= 1'b0;
      rdat_q  <= 16'h0000;
    end else begin
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      ss_q    <= ss_d;
      se_q    <= se_d;
      pst_q   <= pst_d;
      pcur_q  <= pcur_d;
      st_q    <= st_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      flag_q  <= flag_d;
      vs_q    <= vs_d;
      armed_q <= armed_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
    end
  end

  assign bus.data_m_ack      = ack_q;
  assign bus.data_m_data_out = rdat_q;

  assign cursor_enabled    = (mode_q != 2'b01);
  assign cursor_visible    = cursor_enabled &
                             ((mode_q == 2'b10) | phase_q);
  assign cursor_pos        = cur_q;
  assign start_addr        = st_q;
  assign cursor_scan_start = ss_q;
  assign cursor_scan_end   = se_q;

endmodule
